// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM state encoding,
// grant encoding and default bus widths.
package mem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_t;

  // The master that did not hold the given grant.
  function automatic gnt_t gnt_other(input gnt_t g);
    return (g == GNT_M0) ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-way grant selector for mem_arbiter.
// Default build: fixed priority, M1 (load/store) over M0 (fetch).
// With ARB_ROUND_ROBIN_EN defined: on a simultaneous request the master
// that did not win last time is picked.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef ARB_ROUND_ROBIN_EN
  input  gnt_t last_grant,
`endif
  output logic any,
  output gnt_t gnt
);

  // Select a winner among the requesting masters.
  always_comb begin
    any = req0 | req1;
    gnt = GNT_M0;
`ifdef ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      gnt = gnt_other(last_grant);
    end else if (req1) begin
      gnt = GNT_M1;
    end
`else
    if (req1) begin
      gnt = GNT_M1;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter between the CPU core and memory.
// M0 = instruction fetch (read-only), M1 = load/store. One transaction is
// outstanding at a time; every transaction walks IDLE -> REQ -> RSP.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests instead of fixed M1-over-M0 priority).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // M0: instruction fetch
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [AW-1:0]     m0_req_addr,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [DW-1:0]     m0_rsp_rdata,
  output logic              m0_rsp_err,
  // M1: load/store
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [AW-1:0]     m1_req_addr,
  input  logic [DW-1:0]     m1_req_wdata,
  input  logic [DW/8-1:0]   m1_req_wstrb,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [DW-1:0]     m1_rsp_rdata,
  output logic              m1_rsp_err,
  // Slave port
  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic              s_req_we,
  output logic [AW-1:0]     s_req_addr,
  output logic [DW-1:0]     s_req_wdata,
  output logic [DW/8-1:0]   s_req_wstrb,
  input  logic              s_rsp_valid,
  output logic              s_rsp_ready,
  input  logic [DW-1:0]     s_rsp_rdata,
  input  logic              s_rsp_err
);

  localparam int SW = DW / 8;

  state_t          state_q;
  state_t          state_d;
  gnt_t            grant_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;

  logic            pick_any;
  gnt_t            pick_gnt;
  logic            accept;
  logic            rsp_ready;

`ifdef ARB_ROUND_ROBIN_EN
  gnt_t            last_grant_q;
`endif

  arb_pick u_pick (
    .req0       (m0_req_valid),
    .req1       (m1_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .any        (pick_any),
    .gnt        (pick_gnt)
  );

  // A request is taken only while idle; this is the single accept cycle.
  assign accept = (state_q == IDLE) && pick_any;

  // Slave request payload always comes from the latched registers so it
  // stays stable while the slave stalls.
  assign s_req_we    = we_q;
  assign s_req_addr  = addr_q;
  assign s_req_wdata = wdata_q;
  assign s_req_wstrb = wstrb_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch grant and request payload at accept; fetch requests carry no write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= GNT_M0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      grant_q <= pick_gnt;
      if (pick_gnt == GNT_M1) begin
        we_q    <= m1_req_we;
        addr_q  <= m1_req_addr;
        wdata_q <= m1_req_wdata;
        wstrb_q <= m1_req_wstrb;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= m0_req_addr;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who won the most recent accept for round-robin fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_M0;
    end else if (accept) begin
      last_grant_q <= pick_gnt;
    end
  end
`endif

  // Next-state logic and handshake outputs; responses route only to the granted master.
  always_comb begin
    state_d      = state_q;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    s_req_valid  = 1'b0;
    rsp_ready    = 1'b0;
    m0_rsp_valid = 1'b0;
    m0_rsp_rdata = '0;
    m0_rsp_err   = 1'b0;
    m1_rsp_valid = 1'b0;
    m1_rsp_rdata = '0;
    m1_rsp_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = REQ;
          if (pick_gnt == GNT_M1) begin
            m1_req_ready = 1'b1;
          end else begin
            m0_req_ready = 1'b1;
          end
        end
      end

      REQ: begin
        s_req_valid = 1'b1;
        if (s_req_ready) begin
          state_d = RSP;
        end
      end

      RSP: begin
        if (grant_q == GNT_M1) begin
          rsp_ready    = m1_rsp_ready;
          m1_rsp_valid = s_rsp_valid;
          m1_rsp_rdata = we_q ? '0 : s_rsp_rdata;
          m1_rsp_err   = s_rsp_err;
        end else begin
          rsp_ready    = m0_rsp_ready;
          m0_rsp_valid = s_rsp_valid;
          m0_rsp_rdata = s_rsp_rdata;
          m0_rsp_err   = s_rsp_err;
        end
        if (s_rsp_valid && rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // While reset is held no handshake may be offered, even combinationally.
    if (rst) begin
      m0_req_ready = 1'b0;
      m1_req_ready = 1'b0;
      s_req_valid  = 1'b0;
      rsp_ready    = 1'b0;
      m0_rsp_valid = 1'b0;
      m1_rsp_valid = 1'b0;
    end
  end

  assign s_rsp_ready = rsp_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_req_valid, m0_req_ready;
  logic [AW-1:0]   m0_req_addr;
  logic            m0_rsp_valid, m0_rsp_ready;
  logic [DW-1:0]   m0_rsp_rdata;
  logic            m0_rsp_err;
  logic            m1_req_valid, m1_req_ready, m1_req_we;
  logic [AW-1:0]   m1_req_addr;
  logic [DW-1:0]   m1_req_wdata;
  logic [SW-1:0]   m1_req_wstrb;
  logic            m1_rsp_valid, m1_rsp_ready;
  logic [DW-1:0]   m1_rsp_rdata;
  logic            m1_rsp_err;
  logic            s_req_valid, s_req_ready, s_req_we;
  logic [AW-1:0]   s_req_addr;
  logic [DW-1:0]   s_req_wdata;
  logic [SW-1:0]   s_req_wstrb;
  logic            s_rsp_valid, s_rsp_ready;
  logic [DW-1:0]   s_rsp_rdata;
  logic            s_rsp_err;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_req_addr  (m0_req_addr),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_ready (m0_rsp_ready),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m0_rsp_err   (m0_rsp_err),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_req_we    (m1_req_we),
    .m1_req_addr  (m1_req_addr),
    .m1_req_wdata (m1_req_wdata),
    .m1_req_wstrb (m1_req_wstrb),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_ready (m1_rsp_ready),
    .m1_rsp_rdata (m1_rsp_rdata),
    .m1_rsp_err   (m1_rsp_err),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req_we     (s_req_we),
    .s_req_addr   (s_req_addr),
    .s_req_wdata  (s_req_wdata),
    .s_req_wstrb  (s_req_wstrb),
    .s_rsp_valid  (s_rsp_valid),
    .s_rsp_ready  (s_rsp_ready),
    .s_rsp_rdata  (s_rsp_rdata),
    .s_rsp_err    (s_rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_valid = 1'b0; m0_req_addr = '0; m0_rsp_ready = 1'b0;
    m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = '0;
    m1_req_wdata = '0; m1_req_wstrb = '0; m1_rsp_ready = 1'b0;
    s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_rdata = '0; s_rsp_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] hs;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_req_valid = 1'($urandom_range(0, 1));
      m0_req_addr  = $urandom;
      m0_rsp_ready = 1'($urandom_range(0, 1));
      m1_req_valid = 1'($urandom_range(0, 1));
      m1_req_we    = 1'($urandom_range(0, 1));
      m1_req_addr  = $urandom;
      m1_req_wdata = $urandom;
      m1_req_wstrb = 4'($urandom);
      m1_rsp_ready = 1'($urandom_range(0, 1));
      s_req_ready  = 1'($urandom_range(0, 1));
      s_rsp_valid  = 1'($urandom_range(0, 1));
      s_rsp_rdata  = $urandom;
      s_rsp_err    = 1'($urandom_range(0, 1));
      #2;
      hs = {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready};
      tests++;
      if (hs !== 6'b0) begin
        fails++;
        $display("FAIL reset_handshakes[%0d]: got %b expected 000000", i, hs);
      end
      tests++;
      if (s_req_addr !== '0 || s_req_wdata !== '0 || s_req_we !== 1'b0 || s_req_wstrb !== '0) begin
        fails++;
        $display("FAIL reset_payload[%0d]: got addr=%h wdata=%h we=%b wstrb=%h expected all 0",
                 i, s_req_addr, s_req_wdata, s_req_we, s_req_wstrb);
      end
      tick();
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    // Idle after release: an unsolicited slave response must be ignored.
    s_rsp_valid = 1'b1;
    #1;
    tests++;
    if (s_req_valid !== 1'b0 || s_rsp_ready !== 1'b0 || m0_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got s_req_valid=%b s_rsp_ready=%b m0_rsp_valid=%b expected 0 0 0",
               s_req_valid, s_rsp_ready, m0_rsp_valid);
    end
    s_rsp_valid = 1'b0;
    tick();
  endtask

  task automatic test_m0_read();
    m0_req_valid = 1'b1;
    m0_req_addr  = 32'h8000_0000;
    #1;
    tests++;
    if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
      fails++;
      $display("FAIL m0_accept: got m0_ready=%b m1_ready=%b expected 1 0", m0_req_ready, m1_req_ready);
    end
    tick();
    m0_req_valid = 1'b0;
    m0_req_addr  = '0;
    #1;
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000 || s_req_we !== 1'b0 || m0_req_ready !== 1'b0) begin
      fails++;
      $display("FAIL m0_slave_req: got valid=%b addr=%h we=%b m0_ready=%b expected 1 80000000 0 0",
               s_req_valid, s_req_addr, s_req_we, m0_req_ready);
    end
    s_req_ready = 1'b1;
    tick();
    s_req_ready  = 1'b0;
    m0_rsp_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      #1;
      tests++;
      if (m0_rsp_valid !== 1'b0 || s_req_valid !== 1'b0) begin
        fails++;
        $display("FAIL m0_wait[%0d]: got rsp_valid=%b s_req_valid=%b expected 0 0", w, m0_rsp_valid, s_req_valid);
      end
      tick();
    end
    s_rsp_valid = 1'b1;
    s_rsp_rdata = 32'hDEAD_BEEF;
    s_rsp_err   = 1'b0;
    #1;
    tests++;
    if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'hDEAD_BEEF || m0_rsp_err !== 1'b0 ||
        s_rsp_ready !== 1'b1 || m1_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL m0_rsp: got valid=%b rdata=%h err=%b s_rsp_ready=%b m1_valid=%b expected 1 deadbeef 0 1 0",
               m0_rsp_valid, m0_rsp_rdata, m0_rsp_err, s_rsp_ready, m1_rsp_valid);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (s_req_valid !== 1'b0 || m0_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL m0_done: got s_req_valid=%b m0_rsp_valid=%b expected 0 0", s_req_valid, m0_rsp_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic          exp_m1_first;
    logic          cur_m1;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [SW-1:0] exp_wstrb;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] slv_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    // Prior lone M1 transaction so the round-robin pointer favours M0.
    m1_req_valid = 1'b1; m1_req_addr = 32'h8000_0100;
    tick();
    m1_req_valid = 1'b0; s_req_ready = 1'b1;
    tick();
    s_req_ready = 1'b0; s_rsp_valid = 1'b1; m1_rsp_ready = 1'b1;
    tick();
    idle_inputs();
    exp_m1_first = 1'b0;
`else
    exp_m1_first = 1'b1;
`endif
    m0_req_valid = 1'b1;
    m0_req_addr  = 32'h8000_0000;
    m1_req_valid = 1'b1;
    m1_req_we    = 1'b1;
    m1_req_addr  = 32'h8000_0010;
    m1_req_wdata = 32'h0000_1234;
    m1_req_wstrb = 4'hF;
    for (int ph = 0; ph < 2; ph++) begin
      cur_m1 = (ph == 0) ? exp_m1_first : ~exp_m1_first;
      #1;
      tests++;
      if (m1_req_ready !== cur_m1 || m0_req_ready !== ~cur_m1) begin
        fails++;
        $display("FAIL sim_grant[%0d]: got m0_ready=%b m1_ready=%b expected %b %b",
                 ph, m0_req_ready, m1_req_ready, ~cur_m1, cur_m1);
      end
      tick();
      if (cur_m1) m1_req_valid = 1'b0;
      else        m0_req_valid = 1'b0;
      exp_we    = cur_m1;
      exp_addr  = cur_m1 ? 32'h8000_0010 : 32'h8000_0000;
      exp_wdata = cur_m1 ? 32'h0000_1234 : 32'h0;
      exp_wstrb = cur_m1 ? 4'hF : 4'h0;
      #1;
      tests++;
      if (s_req_valid !== 1'b1 || s_req_we !== exp_we || s_req_addr !== exp_addr ||
          s_req_wdata !== exp_wdata || s_req_wstrb !== exp_wstrb || m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0) begin
        fails++;
        $display("FAIL sim_payload[%0d]: got v=%b we=%b addr=%h wdata=%h wstrb=%h rdy=%b%b expected 1 %b %h %h %h 00",
                 ph, s_req_valid, s_req_we, s_req_addr, s_req_wdata, s_req_wstrb, m0_req_ready, m1_req_ready,
                 exp_we, exp_addr, exp_wdata, exp_wstrb);
      end
      s_req_ready = 1'b1;
      tick();
      s_req_ready  = 1'b0;
      slv_rdata    = 32'h600D_0000 + 32'(ph);
      s_rsp_valid  = 1'b1;
      s_rsp_rdata  = slv_rdata;
      m0_rsp_ready = 1'b1;
      m1_rsp_ready = 1'b1;
      exp_rdata    = cur_m1 ? 32'h0 : slv_rdata;
      #1;
      tests++;
      if (m1_rsp_valid !== cur_m1 || m0_rsp_valid !== ~cur_m1 ||
          (cur_m1 ? m1_rsp_rdata : m0_rsp_rdata) !== exp_rdata) begin
        fails++;
        $display("FAIL sim_rsp[%0d]: got m0_v=%b m1_v=%b m0_rd=%h m1_rd=%h expected m1_v=%b rdata=%h",
                 ph, m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata, cur_m1, exp_rdata);
      end
      tick();
      s_rsp_valid  = 1'b0;
      m0_rsp_ready = 1'b0;
      m1_rsp_ready = 1'b0;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    m1_req_valid = 1'b1;
    m1_req_we    = 1'b1;
    m1_req_addr  = 32'h8000_0020;
    m1_req_wdata = 32'hCAFE_F00D;
    m1_req_wstrb = 4'h3;
    tick();
    m1_req_valid = 1'b0;
    m1_req_addr  = 32'h1111_1111;
    m1_req_wdata = 32'h2222_2222;
    m1_req_wstrb = 4'hC;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0020 || s_req_wdata !== 32'hCAFE_F00D ||
          s_req_wstrb !== 4'h3 || s_req_we !== 1'b1) begin
        fails++;
        $display("FAIL stall[%0d]: got v=%b addr=%h wdata=%h wstrb=%h we=%b expected 1 80000020 cafef00d 3 1",
                 c, s_req_valid, s_req_addr, s_req_wdata, s_req_wstrb, s_req_we);
      end
      tick();
    end
    s_req_ready = 1'b1;
    tick();
    s_req_ready  = 1'b0;
    s_rsp_valid  = 1'b1;
    m1_rsp_ready = 1'b1;
    #1;
    tests++;
    if (m1_rsp_valid !== 1'b1 || m1_rsp_rdata !== 32'h0 || s_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_rsp: got valid=%b rdata=%h s_req_valid=%b expected 1 0 0",
               m1_rsp_valid, m1_rsp_rdata, s_req_valid);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_error();
    m1_req_valid = 1'b1;
    m1_req_we    = 1'b0;
    m1_req_addr  = 32'h8000_0030;
    tick();
    m1_req_valid = 1'b0;
    s_req_ready  = 1'b1;
    tick();
    s_req_ready  = 1'b0;
    s_rsp_valid  = 1'b1;
    s_rsp_err    = 1'b1;
    s_rsp_rdata  = 32'h1234_5678;
    m1_rsp_ready = 1'b0;
    #1;
    tests++;
    if (m1_rsp_valid !== 1'b1 || s_rsp_ready !== 1'b0) begin
      fails++;
      $display("FAIL err_backpressure: got m1_valid=%b s_rsp_ready=%b expected 1 0", m1_rsp_valid, s_rsp_ready);
    end
    tick();
    m1_rsp_ready = 1'b1;
    #1;
    tests++;
    if (m1_rsp_valid !== 1'b1 || m1_rsp_err !== 1'b1 || m1_rsp_rdata !== 32'h1234_5678 || s_rsp_ready !== 1'b1) begin
      fails++;
      $display("FAIL err_rsp: got valid=%b err=%b rdata=%h s_rsp_ready=%b expected 1 1 12345678 1",
               m1_rsp_valid, m1_rsp_err, m1_rsp_rdata, s_rsp_ready);
    end
    tick();
    // Slave keeps s_rsp_valid high after the handshake: must be ignored in IDLE.
    #1;
    tests++;
    if (m1_rsp_valid !== 1'b0 || m1_rsp_err !== 1'b0 || s_rsp_ready !== 1'b0 || s_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_idle: got m1_valid=%b err=%b s_rsp_ready=%b s_req_valid=%b expected 0 0 0 0",
               m1_rsp_valid, m1_rsp_err, s_rsp_ready, s_req_valid);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_rsp();
    m0_req_valid = 1'b1;
    m0_req_addr  = 32'h8000_0040;
    tick();
    m0_req_valid = 1'b0;
    s_req_ready  = 1'b1;
    tick();
    s_req_ready  = 1'b0;
    s_rsp_valid  = 1'b1;
    s_rsp_rdata  = 32'hA5A5_A5A5;
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;
    #1;
    tests++;
    if (m0_rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rstrsp_pre: got m0_rsp_valid=%b expected 1", m0_rsp_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (m0_rsp_valid !== 1'b0 || s_rsp_ready !== 1'b0 || s_req_valid !== 1'b0 || s_req_addr !== '0) begin
      fails++;
      $display("FAIL rstrsp_clear: got m0_v=%b s_rsp_ready=%b s_req_valid=%b addr=%h expected 0 0 0 0",
               m0_rsp_valid, s_rsp_ready, s_req_valid, s_req_addr);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0 || s_rsp_ready !== 1'b0) begin
        fails++;
        $display("FAIL rstrsp_after[%0d]: got m0_v=%b m1_v=%b s_rsp_ready=%b expected 0 0 0",
                 c, m0_rsp_valid, m1_rsp_valid, s_rsp_ready);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_m0_read();
    test_simultaneous();
    test_stall();
    test_error();
    test_reset_rsp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
